// File: rtl/wb_interconnect_n.sv
// Single-master, NS-slave pipelined Wishbone interconnect with base/mask decode and bus timeout.
// Optional saturating error counter port o_err_count is enabled by defining WB_IC_ERR_COUNT_EN.
module wb_interconnect_n #(
    parameter int NS = 4,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter logic [NS*AW-1:0] SLAVE_BASE = {32'h0000_0000, 32'h8000_0010, 32'h8000_0008, 32'h8000_0000},
    parameter logic [NS*AW-1:0] SLAVE_MASK = {32'hFFFE_0000, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8},
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [DW-1:0]     i_wb_data,
    input  logic [DW/8-1:0]   i_wb_sel,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic [DW-1:0]     o_wb_data,
    output logic [AW-1:0]     o_wb_err_addr,
`ifdef WB_IC_ERR_COUNT_EN
    output logic [15:0]       o_err_count,
`endif
    output logic [NS-1:0]     o_s_cyc,
    output logic [NS-1:0]     o_s_stb,
    output logic [AW-1:0]     o_s_addr,
    output logic [DW-1:0]     o_s_data,
    output logic [DW/8-1:0]   o_s_sel,
    output logic              o_s_we,
    input  logic [NS-1:0]     i_s_ack,
    input  logic [NS-1:0]     i_s_err,
    input  logic [NS-1:0]     i_s_stall,
    input  logic [NS*DW-1:0]  i_s_data
);

    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  tmo_cnt;
    logic           dec_hit;
    logic [IW-1:0]  dec_idx;
    logic           accept;
    logic           ack_set;
    logic           err_set;
    logic           sel_ack;
    logic           sel_err;
    logic           sel_stall;
    logic [DW-1:0]  sel_data;

    // Scan from the top down so the lowest matching slave index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if ((i_wb_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
                dec_hit = 1'b1;
                dec_idx = IW'(i);
            end
        end
    end

    assign sel_ack   = i_s_ack[idx];
    assign sel_err   = i_s_err[idx];
    assign sel_stall = i_s_stall[idx];
    assign sel_data  = i_s_data[idx*DW +: DW];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort beats any response; slave err beats ack; a response on the last timeout cycle still wins.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ack_set    = 1'b0;
        err_set    = 1'b0;
        o_s_cyc    = '0;
        o_s_stb    = '0;
        o_wb_stall = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    accept = 1'b1;
                    if (dec_hit) begin
                        next_state = S_REQ;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            S_REQ, S_WAIT: begin
                o_wb_stall   = 1'b1;
                o_s_cyc[idx] = 1'b1;
                o_s_stb[idx] = (state == S_REQ);
                if (!i_wb_cyc) begin
                    next_state = S_IDLE;
                end else if (sel_err) begin
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end else if (sel_ack) begin
                    ack_set    = 1'b1;
                    next_state = S_IDLE;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    err_set    = 1'b1;
                    next_state = S_IDLE;
                end else if (state == S_REQ && !sel_stall) begin
                    next_state = S_WAIT;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx           <= '0;
            tmo_cnt       <= '0;
            o_s_addr      <= '0;
            o_s_data      <= '0;
            o_s_sel       <= '0;
            o_s_we        <= 1'b0;
            o_wb_ack      <= 1'b0;
            o_wb_err      <= 1'b0;
            o_wb_data     <= '0;
            o_wb_err_addr <= '0;
        end else begin
            o_wb_ack <= ack_set;
            o_wb_err <= err_set;
            if (accept) begin
                idx      <= dec_idx;
                tmo_cnt  <= '0;
                o_s_addr <= i_wb_addr;
                o_s_data <= i_wb_data;
                o_s_sel  <= i_wb_sel;
                o_s_we   <= i_wb_we;
            end else if (state != S_IDLE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (ack_set) begin
                o_wb_data <= sel_data;
            end
            // A decode miss reports the live master address; slave and timeout errors the held one.
            if (err_set) begin
                o_wb_err_addr <= (state == S_IDLE) ? i_wb_addr : o_s_addr;
            end
        end
    end

`ifdef WB_IC_ERR_COUNT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_err_count <= '0;
        end else if (err_set && o_err_count != 16'hFFFF) begin
            o_err_count <= o_err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Self-checking bench for wb_interconnect_n: directed vector table, hand-written corner
// sequences and randomized transactions scored against a transaction-level model.
module tb_wb_interconnect_n;

    localparam int NS  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    typedef enum int {K_ACK, K_ERR, K_BOTH, K_NONE} kind_e;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          stall;
        int          delay;
        kind_e       kind;
        logic [31:0] rdata;
        int          exp_tgt;
        bit          exp_err;
        int          exp_cycle;
        logic [31:0] exp_data;
        int          exp_stb;
        int          exp_cyc;
    } vec_t;

    logic              i_clk = 1'b0;
    logic              i_reset = 1'b1;
    logic              i_wb_cyc = 1'b0;
    logic              i_wb_stb = 1'b0;
    logic              i_wb_we = 1'b0;
    logic [AW-1:0]     i_wb_addr = '0;
    logic [DW-1:0]     i_wb_data = '0;
    logic [DW/8-1:0]   i_wb_sel = '0;
    logic              o_wb_stall;
    logic              o_wb_ack;
    logic              o_wb_err;
    logic [DW-1:0]     o_wb_data;
    logic [AW-1:0]     o_wb_err_addr;
    logic [NS-1:0]     o_s_cyc;
    logic [NS-1:0]     o_s_stb;
    logic [AW-1:0]     o_s_addr;
    logic [DW-1:0]     o_s_data;
    logic [DW/8-1:0]   o_s_sel;
    logic              o_s_we;
    logic [NS-1:0]     i_s_ack = '0;
    logic [NS-1:0]     i_s_err = '0;
    logic [NS-1:0]     i_s_stall = '0;
    logic [NS*DW-1:0]  i_s_data = '0;
`ifdef WB_IC_ERR_COUNT_EN
    logic [15:0]       o_err_count;
`endif

    int tests = 0;
    int fails = 0;
    int model_errs = 0;
    int n_stb, n_cyc, n_stall, n_stray, n_both;
    bit snap_done;
    logic [127:0] snap;

    logic [31:0] mdl_base [4] = '{32'h8000_0000, 32'h8000_0008, 32'h8000_0010, 32'h0000_0000};
    logic [31:0] mdl_mask [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFE_0000};

    always #5 i_clk = ~i_clk;

    wb_interconnect_n #(
        .NS(NS), .AW(AW), .DW(DW), .TIMEOUT(TMO)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .o_wb_data(o_wb_data), .o_wb_err_addr(o_wb_err_addr),
`ifdef WB_IC_ERR_COUNT_EN
        .o_err_count(o_err_count),
`endif
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_addr(o_s_addr),
        .o_s_data(o_s_data), .o_s_sel(o_s_sel), .o_s_we(o_s_we),
        .i_s_ack(i_s_ack), .i_s_err(i_s_err), .i_s_stall(i_s_stall),
        .i_s_data(i_s_data)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkErrCount();
`ifdef WB_IC_ERR_COUNT_EN
        checkOutput("err_count", 128'(o_err_count), 128'(model_errs));
`endif
    endtask

    // Transaction-level model: lowest matching region is the target, first of response/timeout ends it.
    function automatic vec_t modelTxn(input vec_t v);
        vec_t r = v;
        int   resp;
        int   fin;
        r.exp_tgt = -1;
        for (int i = 0; i < 4; i++) begin
            if (r.exp_tgt < 0 && (v.addr & mdl_mask[i]) == mdl_base[i]) r.exp_tgt = i;
        end
        r.exp_data = 32'h0;
        if (r.exp_tgt < 0) begin
            r.exp_err = 1'b1; r.exp_cycle = 1; r.exp_stb = 0; r.exp_cyc = 0;
            return r;
        end
        resp = v.stall + 1 + v.delay;
        if (v.kind != K_NONE && resp <= TMO) begin
            fin = resp;
            r.exp_err = (v.kind != K_ACK);
            r.exp_data = v.rdata;
        end else begin
            fin = TMO;
            r.exp_err = 1'b1;
        end
        r.exp_cycle = fin + 1;
        r.exp_cyc = fin;
        r.exp_stb = (v.stall + 1 < fin) ? v.stall + 1 : fin;
        return r;
    endfunction

    task automatic idleSlaves();
        i_s_ack = '0; i_s_err = '0; i_s_stall = '0; i_s_data = '0;
    endtask

    task automatic driveSlaves(input vec_t v, input int c);
        int resp = v.stall + 1 + v.delay;
        for (int i = 0; i < NS; i++) begin
            i_s_ack[i]   = ($urandom_range(0, 3) == 0);
            i_s_err[i]   = ($urandom_range(0, 7) == 0);
            i_s_stall[i] = 1'($urandom_range(0, 1));
            i_s_data[i*DW +: DW] = $urandom;
        end
        if (v.exp_tgt >= 0) begin
            i_s_ack[v.exp_tgt]   = (c == resp) && (v.kind == K_ACK || v.kind == K_BOTH);
            i_s_err[v.exp_tgt]   = (c == resp) && (v.kind == K_ERR || v.kind == K_BOTH);
            i_s_stall[v.exp_tgt] = (c <= v.stall);
            i_s_data[v.exp_tgt*DW +: DW] = v.rdata;
        end
    endtask

    task automatic sampleCycle(input logic [3:0] tmask);
        n_stb   += ((o_s_stb & tmask) != 0) ? 1 : 0;
        n_cyc   += ((o_s_cyc & tmask) != 0) ? 1 : 0;
        n_stall += o_wb_stall ? 1 : 0;
        n_stray += (((o_s_stb | o_s_cyc) & ~tmask) != 0) ? 1 : 0;
        n_both  += (o_wb_ack && o_wb_err) ? 1 : 0;
        if (!snap_done && (o_s_stb & tmask) != 0) begin
            snap = {59'b0, o_s_addr, o_s_data, o_s_sel, o_s_we};
            snap_done = 1'b1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [3:0]  tmask;
        int          resp_cycle = 0;
        bit          resp_err = 1'b0;
        logic [31:0] resp_data = '0;
        logic [31:0] resp_eaddr = '0;
        bit          pulse;
        tmask = (v.exp_tgt >= 0) ? 4'(1 << v.exp_tgt) : 4'b0;
        n_stb = 0; n_cyc = 0; n_stall = 0; n_stray = 0; n_both = 0; snap_done = 1'b0; snap = '0;
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = v.we;
        i_wb_addr = v.addr; i_wb_data = v.wdata; i_wb_sel = v.sel;
        idleSlaves();
        @(negedge i_clk);
        sampleCycle(tmask);
        for (int c = 1; c <= TMO + 12; c++) begin
            @(posedge i_clk); #1;
            i_wb_stb = 1'b0;
            driveSlaves(v, c);
            @(negedge i_clk);
            sampleCycle(tmask);
            if (o_wb_ack || o_wb_err) begin
                resp_cycle = c; resp_err = o_wb_err;
                resp_data = o_wb_data; resp_eaddr = o_wb_err_addr;
                break;
            end
        end
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b0;
        idleSlaves();
        @(negedge i_clk);
        pulse = o_wb_ack || o_wb_err;
        if (v.exp_err) model_errs++;
        checkOutput("resp_cycle", 128'(resp_cycle), 128'(v.exp_cycle));
        checkOutput("resp_err", 128'(resp_err), 128'(v.exp_err));
        if (v.exp_err) checkOutput("err_addr", 128'(resp_eaddr), 128'(v.addr));
        else checkOutput("rdata", 128'(resp_data), 128'(v.exp_data));
        checkOutput("stb_cycles", 128'(n_stb), 128'(v.exp_stb));
        checkOutput("cyc_cycles", 128'(n_cyc), 128'(v.exp_cyc));
        checkOutput("stall_cycles", 128'(n_stall), 128'(v.exp_cyc));
        checkOutput("stray_slave", 128'(n_stray), 128'(0));
        checkOutput("ack_and_err", 128'(n_both), 128'(0));
        checkOutput("pulse_width", 128'(pulse), 128'(0));
        if (v.exp_tgt >= 0) checkOutput("req_bus", snap, {59'b0, v.addr, v.wdata, v.sel, v.we});
        checkErrCount();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs [11];
        vec_t v;

        vecs[0]  = '{32'h8000_0004, 1'b0, 32'h0000_0011, 4'hF, 0, 1, K_ACK,  32'h0000_002A, 0,  1'b0, 3, 32'h0000_002A, 1, 2};
        vecs[1]  = '{32'h8000_0010, 1'b1, 32'h0000_1234, 4'hF, 3, 1, K_ACK,  32'hDEAD_0002, 2,  1'b0, 6, 32'hDEAD_0002, 4, 5};
        vecs[2]  = '{32'h4000_0000, 1'b0, 32'h0000_0000, 4'hF, 0, 1, K_ACK,  32'h0000_0000, -1, 1'b1, 1, 32'h0,         0, 0};
        vecs[3]  = '{32'h0000_0100, 1'b0, 32'h0000_0000, 4'hF, 0, 1, K_NONE, 32'h0000_0000, 3,  1'b1, 9, 32'h0,         1, 8};
        vecs[4]  = '{32'h8000_000C, 1'b0, 32'h0000_0005, 4'h3, 0, 2, K_ERR,  32'h0000_0000, 1,  1'b1, 4, 32'h0,         1, 3};
        vecs[5]  = '{32'h8000_0017, 1'b0, 32'h0000_0006, 4'h1, 1, 2, K_ACK,  32'hA5A5_0006, 2,  1'b0, 5, 32'hA5A5_0006, 2, 4};
        vecs[6]  = '{32'h0001_FFFC, 1'b0, 32'h0000_0007, 4'hF, 0, 7, K_ACK,  32'h1357_9BDF, 3,  1'b0, 9, 32'h1357_9BDF, 1, 8};
        vecs[7]  = '{32'h0000_0000, 1'b0, 32'h0000_0008, 4'hF, 0, 8, K_ACK,  32'h2468_ACE0, 3,  1'b1, 9, 32'h0,         1, 8};
        vecs[8]  = '{32'h8000_0018, 1'b0, 32'h0000_0009, 4'hF, 0, 1, K_ACK,  32'h0000_0000, -1, 1'b1, 1, 32'h0,         0, 0};
        vecs[9]  = '{32'h8000_0000, 1'b1, 32'hCAFE_000A, 4'hC, 9, 1, K_ACK,  32'h0000_0000, 0,  1'b1, 9, 32'h0,         8, 8};
        vecs[10] = '{32'h8000_000F, 1'b0, 32'h0000_000B, 4'hF, 2, 1, K_BOTH, 32'h7777_7777, 1,  1'b1, 5, 32'h0,         3, 4};

        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("rst_ack", 128'(o_wb_ack), 128'(0));
        checkOutput("rst_err", 128'(o_wb_err), 128'(0));
        checkOutput("rst_stall", 128'(o_wb_stall), 128'(0));
        checkOutput("rst_s_cyc", 128'(o_s_cyc), 128'(0));
        checkOutput("rst_s_stb", 128'(o_s_stb), 128'(0));
        checkOutput("rst_err_addr", 128'(o_wb_err_addr), 128'(0));
        checkErrCount();

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Slave1 answers ack+err together; the next request rides the err pulse cycle.
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 32'h8000_0008;
        @(posedge i_clk); #1;
        i_wb_stb = 1'b0;
        @(negedge i_clk);
        checkOutput("b2b_stb1", 128'(o_s_stb), 128'(4'b0010));
        @(posedge i_clk); #1;
        i_s_ack = 4'b0010; i_s_err = 4'b0010; i_s_data[1*DW +: DW] = 32'h0BAD_0BAD;
        @(posedge i_clk); #1;
        idleSlaves();
        i_wb_stb = 1'b1; i_wb_addr = 32'h8000_0000;
        @(negedge i_clk);
        model_errs++;
        checkOutput("b2b_err", 128'({o_wb_err, o_wb_ack, o_wb_stall}), 128'(3'b100));
        checkOutput("b2b_err_addr", 128'(o_wb_err_addr), 128'(32'h8000_0008));
        checkErrCount();
        @(posedge i_clk); #1;
        i_wb_stb = 1'b0;
        @(negedge i_clk);
        checkOutput("b2b_stb0", 128'(o_s_stb), 128'(4'b0001));
        @(posedge i_clk); #1;
        i_s_ack = 4'b0001; i_s_data[0 +: DW] = 32'h0000_0055;
        @(posedge i_clk); #1;
        idleSlaves();
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
        checkOutput("b2b_ack", 128'({o_wb_ack, o_wb_err}), 128'(2'b10));
        checkOutput("b2b_data", 128'(o_wb_data), 128'(32'h0000_0055));

        // Master abandons the cycle while waiting; the late slave ack must vanish.
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_addr = 32'h8000_0008;
        @(posedge i_clk); #1;
        i_wb_stb = 1'b0;
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b0;
        @(negedge i_clk);
        checkOutput("abort_wait_cyc", 128'({o_s_cyc, o_s_stb}), 128'(8'b0010_0000));
        @(posedge i_clk); #1;
        i_s_ack = 4'b0010; i_s_data[1*DW +: DW] = 32'h1111_2222;
        @(negedge i_clk);
        checkOutput("abort_dropped", 128'({o_s_cyc, o_wb_stall}), 128'(0));
        @(posedge i_clk); #1;
        idleSlaves();
        @(negedge i_clk);
        checkOutput("abort_no_resp", 128'({o_wb_ack, o_wb_err}), 128'(0));
        applyStimulus(vecs[0]);

        for (int n = 0; n < 40; n++) begin
            int k;
            case ($urandom_range(0, 4))
                0: v.addr = 32'h8000_0000 | 32'($urandom_range(0, 7));
                1: v.addr = 32'h8000_0008 | 32'($urandom_range(0, 7));
                2: v.addr = 32'h8000_0010 | 32'($urandom_range(0, 7));
                3: v.addr = 32'($urandom_range(0, 32'h1FFFF));
                default: v.addr = $urandom;
            endcase
            v.we    = 1'($urandom_range(0, 1));
            v.wdata = $urandom;
            v.sel   = 4'($urandom_range(0, 15));
            v.stall = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
            v.delay = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 8)) : int'($urandom_range(1, 4));
            v.rdata = $urandom;
            k = int'($urandom_range(0, 9));
            if (k <= 5) v.kind = K_ACK;
            else if (k == 6) v.kind = K_ERR;
            else if (k == 7) v.kind = K_BOTH;
            else v.kind = K_NONE;
            v = modelTxn(v);
            applyStimulus(v);
        end

        // Synchronous reset while slave2 holds the request stalled.
        @(posedge i_clk); #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_addr = 32'h8000_0010;
        @(posedge i_clk); #1;
        i_wb_stb = 1'b0; i_s_stall = 4'b0100; i_reset = 1'b1;
        @(negedge i_clk);
        checkOutput("rst_pre_stb", 128'(o_s_stb), 128'(4'b0100));
        @(posedge i_clk); #1;
        i_reset = 1'b0; i_wb_cyc = 1'b0; i_s_stall = '0; i_s_ack = 4'b0100;
        @(negedge i_clk);
        model_errs = 0;
        checkOutput("rst_mid_bus", 128'({o_s_cyc, o_s_stb, o_wb_stall, o_wb_ack, o_wb_err}), 128'(0));
        checkOutput("rst_mid_data", 128'({o_wb_data, o_wb_err_addr}), 128'(0));
        checkErrCount();
        @(posedge i_clk); #1;
        idleSlaves();
        @(negedge i_clk);
        checkOutput("rst_no_resp", 128'({o_wb_ack, o_wb_err}), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_interconnect_n.md
Name: wb_interconnect_n

Overview:
Parametrised single-master, NS-slave Wishbone (pipelined) interconnect. It decodes each master request against per-slave base/mask pairs and forwards the strobe to exactly one slave. It returns registered ack, data and err to the master and enforces a bus timeout. It sits between the picorv32 Wishbone bridge and the SoC peripherals (SRAM, LEDs, UART, countdown timer). Exactly one transaction is outstanding at a time.

Parameters:
NS, 4, number of slaves (1..8)
AW, 32, address width
DW, 32, data width
SLAVE_BASE, {32'h0000_0000, 32'h8000_0010, 32'h8000_0008, 32'h8000_0000}, flattened NS*AW; slave i = bits [i*AW +: AW]
SLAVE_MASK, {32'hFFFE_0000, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFF8}, flattened NS*AW; slave i matches when (addr & mask_i) == base_i
TIMEOUT, 255, cycles in REQ+WAIT before bus error (>=2)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_wb_cyc/i_wb_stb/i_wb_we  in  1 each  master cycle, strobe, write enable
i_wb_addr  in  AW  master address
i_wb_data  in  DW  master write data
i_wb_sel  in  DW/8  byte selects
o_wb_stall  out  1  master stall
o_wb_ack  out  1  master ack, one-cycle pulse
o_wb_err  out  1  master error, one-cycle pulse
o_wb_data  out  DW  read data, valid with o_wb_ack
o_wb_err_addr  out  AW  address of last errored request
o_s_cyc  out  NS  per-slave cycle
o_s_stb  out  NS  per-slave strobe
o_s_addr/o_s_data/o_s_sel/o_s_we  out  AW/DW/DW/8/1  registered request, broadcast to all slaves
i_s_ack/i_s_err/i_s_stall  in  NS each  per-slave responses
i_s_data  in  NS*DW  slave i read data = [i*DW +: DW]

Behaviour:
- Reset: all outputs 0; state IDLE; timeout counter 0.
- Decode: combinational on i_wb_addr. If several slaves match, lowest index wins. No match means a decode error.
- IDLE: o_wb_stall=0. On i_wb_cyc&&i_wb_stb:
  - Register addr/data/sel/we and the address.
  - Hit: latch slave index, go to REQ.
  - Miss: no slave strobed; o_wb_err=1 next cycle; o_wb_err_addr<=i_wb_addr; stay IDLE.
- REQ: o_s_cyc[idx]=o_s_stb[idx]=1; o_wb_stall=1. When !i_s_stall[idx], go to WAIT with o_s_stb dropped and o_s_cyc held.
- WAIT: o_s_cyc[idx]=1; o_wb_stall=1.
- Responses: i_s_ack[idx] or i_s_err[idx] is honoured in REQ or WAIT.
  - Ack: o_wb_ack=1 and o_wb_data<=i_s_data[idx] on the next cycle; go to IDLE.
  - Err: o_wb_err=1 next cycle and o_wb_err_addr latched; go to IDLE.
  - Ack and err in the same cycle: err wins, no ack.
- Responses from non-selected slaves are ignored.
- Minimum latency: master strobe at cycle 0, slave strobe at cycle 1, slave ack at cycle 2, master ack at cycle 3.
- Back-to-back: a new request is accepted in IDLE in the same cycle the previous ack/err pulses.
- Timeout: counter clears on entering REQ and increments each REQ/WAIT cycle. When it reaches TIMEOUT-1 with no response: o_wb_err next cycle, address latched, slave cyc/stb dropped, go to IDLE.
- Abort: i_wb_cyc low in REQ or WAIT drops slave cyc/stb next cycle and returns to IDLE. No ack or err is issued, and a late slave ack is ignored.
- o_wb_data holds its last value when no ack is pulsing. o_wb_err_addr holds until the next error.
- i_reset mid-transaction: immediate return to IDLE, all strobes low, no response pulse.
- Only one of o_wb_ack/o_wb_err is high in any cycle. At most one bit of o_s_cyc/o_s_stb is set.

Optional Feature:
WB_IC_ERR_COUNT_EN
- Defined: adds output o_err_count[15:0]. It is a saturating count (stops at 16'hFFFF) of decode, slave and timeout errors, cleared by i_reset. It increments in the same cycle o_wb_err pulses.
- Undefined: the port and the counter are absent.

Test Plan:
- Read 0x8000_0004 with slave0 acking 1 cycle after strobe, data 0x0000_002A -> o_s_stb=4'b0001 for 1 cycle; o_wb_ack at cycle 3 with o_wb_data=0x2A; o_wb_err never high.
- Write 0x8000_0010 with data 0x1234 and slave2 stalled 3 cycles -> o_s_stb[2] high 4 cycles; o_s_data=0x1234; o_wb_stall=1 until return to IDLE; single ack.
- Read 0x4000_0000 (no match) -> no o_s_stb; o_wb_err pulses 1 cycle later; o_wb_err_addr=0x4000_0000.
- Read 0x0000_0100 with slave3 silent and TIMEOUT=8 -> o_wb_err after 8 REQ/WAIT cycles; o_s_cyc cleared; o_wb_err_addr=0x0000_0100; with the macro defined, o_err_count=1.
- Slave1 asserts ack and err together for 0x8000_0008 -> err only; next request to 0x8000_0000 accepted in the same cycle and acked normally.
- Master drops i_wb_cyc during WAIT, then slave acks -> no o_wb_ack; state IDLE; next request served.
